// File: rtl/local_port_injection_scheduler_pkg.sv
// Shared constants, flit layout helpers and source state type for the
// local-port injection scheduler.
package local_port_injection_scheduler_pkg;

    localparam int V_DEFAULT    = 4;
    localparam int B_DEFAULT    = 4;
    localparam int FPAY_DEFAULT = 32;
    localparam int NREQ_DEFAULT = 3;

    // Ceiling log2 with a floor of 1 so single-entry fields still get a bit
    function automatic int log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Router flit: {hdr, tail, vc_onehot[V-1:0], payload[FPAY-1:0]}
    function automatic int flit_width(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    localparam int FW       = flit_width(V_DEFAULT, FPAY_DEFAULT);
    localparam int HDR_POS  = FW - 1;
    localparam int TAIL_POS = FW - 2;
    localparam int VC_LSB   = FPAY_DEFAULT;
    localparam int CREDIT_W = log2(B_DEFAULT + 1);

    typedef enum logic {
        SRC_IDLE   = 1'b0,
        SRC_ACTIVE = 1'b1
    } src_state_e;

endpackage

// File: rtl/local_port_injection_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, searching
// upward from the priority pointer; the pointer moves past each winner.
module rr_arbiter
    import local_port_injection_scheduler_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = log2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] winner_lo;
    logic [PTR_W-1:0] winner_hi;
    logic [PTR_W-1:0] winner;
    logic             found_lo;
    logic             found_hi;

    // Pick the first request at or above the pointer, else wrap to the lowest request
    always_comb begin
        winner_lo = '0;
        winner_hi = '0;
        found_lo  = 1'b0;
        found_hi  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_lo = PTR_W'(i);
                found_lo  = 1'b1;
                if (i >= int'(ptr)) begin
                    winner_hi = PTR_W'(i);
                    found_hi  = 1'b1;
                end
            end
        end
        winner   = found_hi ? winner_hi : winner_lo;
        next_ptr = ptr;
        if (found_lo) begin
            next_ptr = (winner == PTR_W'(N - 1)) ? '0 : winner + 1'b1;
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found_lo && (winner == PTR_W'(i));
        end
    end

    // Priority pointer advances to winner+1 only when something was granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/local_port_injection_scheduler.sv
// Shares one router local input port among NREQ sources: allocates a VC per
// packet, tracks per-VC credits and schedules one flit per cycle round-robin.
module local_port_injection_scheduler
    import local_port_injection_scheduler_pkg::*;
#(
    parameter int V    = V_DEFAULT,
    parameter int B    = B_DEFAULT,
    parameter int FPAY = FPAY_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*FPAY-1:0] src_flit,
    input  logic [NREQ-1:0]      src_hdr,
    input  logic [NREQ-1:0]      src_tail,
    input  logic [NREQ-1:0]      src_valid,
    output logic [NREQ-1:0]      src_ready,
    output logic [2+V+FPAY-1:0]  flit_out,
    output logic                 flit_out_we,
    input  logic [V-1:0]         credit_in,
    output logic [V-1:0]         vc_busy
);

    localparam int CRED_W   = log2(B + 1);
    localparam int VC_IDX_W = log2(V);
    localparam logic [CRED_W-1:0] CREDIT_MAX = CRED_W'(B);

    logic [CRED_W-1:0]   credit    [V];
    src_state_e          src_state [NREQ];
    logic [VC_IDX_W-1:0] src_vc    [NREQ];

    logic                free_found;
    logic [VC_IDX_W-1:0] free_vc;
    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant;
    logic                grant_any;
    logic                grant_hdr;
    logic                grant_tail;
    logic [FPAY-1:0]     grant_payload;
    logic [VC_IDX_W-1:0] grant_vc;
    logic [V-1:0]        vc_take;

    // Lowest-index VC that is unowned and still has buffer space downstream
    always_comb begin
        free_found = 1'b0;
        free_vc    = '0;
        for (int v = V - 1; v >= 0; v--) begin
            if (!vc_busy[v] && (credit[v] != '0)) begin
                free_found = 1'b1;
                free_vc    = VC_IDX_W'(v);
            end
        end
    end

    // Open packets continue on their own VC; idle sources may only start with a header
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (reset && src_valid[i]) begin
                if (src_state[i] == SRC_ACTIVE) begin
                    eligible[i] = !src_hdr[i] && (credit[src_vc[i]] != '0);
                end else begin
                    eligible[i] = src_hdr[i] && free_found;
                end
            end
        end
    end

    rr_arbiter #(.N(NREQ)) u_arbiter (
        .clk   (clk),
        .reset (reset),
        .req   (eligible),
        .grant (grant)
    );

    assign src_ready = grant;
    assign grant_any = |grant;

    // Steer the winning source's flit fields and the VC it will travel on
    always_comb begin
        grant_hdr     = 1'b0;
        grant_tail    = 1'b0;
        grant_payload = '0;
        grant_vc      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_hdr     = src_hdr[i];
                grant_tail    = src_tail[i];
                grant_payload = src_flit[i*FPAY +: FPAY];
                grant_vc      = (src_state[i] == SRC_ACTIVE) ? src_vc[i] : free_vc;
            end
        end
        for (int v = 0; v < V; v++) begin
            vc_take[v] = grant_any && (grant_vc == VC_IDX_W'(v));
        end
    end

    // Credit counters: spend one per granted flit, regain one per returned credit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                credit[v] <= CREDIT_MAX;
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !vc_take[v]) begin
                    credit[v] <= (credit[v] == CREDIT_MAX) ? CREDIT_MAX : credit[v] + 1'b1;
                end else if (!credit_in[v] && vc_take[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end

    // VC ownership: claimed by a multi-flit header, released by the tail
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_busy <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (vc_take[v] && grant_tail) begin
                    vc_busy[v] <= 1'b0;
                end else if (vc_take[v] && grant_hdr) begin
                    vc_busy[v] <= 1'b1;
                end
            end
        end
    end

    // Per-source packet state and the VC each open packet owns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                src_state[i] <= SRC_IDLE;
                src_vc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    if (src_tail[i]) begin
                        src_state[i] <= SRC_IDLE;
                    end else if (src_hdr[i]) begin
                        src_state[i] <= SRC_ACTIVE;
                        src_vc[i]    <= free_vc;
                    end
                end
            end
        end
    end

    // Registered router-side flit; the data holds when nothing is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_out    <= '0;
            flit_out_we <= 1'b0;
        end else begin
            flit_out_we <= grant_any;
            if (grant_any) begin
                flit_out <= {grant_hdr, grant_tail, vc_take, grant_payload};
            end
        end
    end

    // An idle source offering a body flit is a protocol violation by that source
    for (genvar i = 0; i < NREQ; i++) begin : g_src_check
        assert property (@(posedge clk) disable iff (!reset)
            !(src_valid[i] && (src_state[i] == SRC_IDLE) && !src_hdr[i]));
    end

    // A returned credit must never push a counter past the buffer depth
    for (genvar v = 0; v < V; v++) begin : g_credit_check
        assert property (@(posedge clk) disable iff (!reset)
            !(credit_in[v] && !vc_take[v] && (credit[v] == CREDIT_MAX)));
    end

endmodule

// File: tb/tb_local_port_injection_scheduler.sv
// Directed bench for the local-port injection scheduler.
module tb_local_port_injection_scheduler;

    logic        clk;
    logic        reset;
    logic [95:0] src_flit;
    logic [2:0]  src_hdr;
    logic [2:0]  src_tail;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [37:0] flit_out;
    logic        flit_out_we;
    logic [3:0]  credit_in;
    logic [3:0]  vc_busy;

    int passCount;
    int failCount;
    int checkCount;

    int          flitIdx [3];
    logic [31:0] pay     [3];
    logic [2:0]  vValid;
    logic [2:0]  vHdr;
    logic [2:0]  vTail;
    logic [3:0]  vBusy;
    int          winner;

    local_port_injection_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .src_flit    (src_flit),
        .src_hdr     (src_hdr),
        .src_tail    (src_tail),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .flit_out    (flit_out),
        .flit_out_we (flit_out_we),
        .credit_in   (credit_in),
        .vc_busy     (vc_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls on the clock
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [37:0] fl(input logic h, input logic t,
                                       input logic [3:0] oh, input logic [31:0] p);
        return {h, t, oh, p};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s differs", tag);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] hdr,
                                 input logic [2:0] tail, input logic [3:0] credit,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [31:0] p2);
        src_valid = valid;
        src_hdr   = hdr;
        src_tail  = tail;
        credit_in = credit;
        src_flit  = {p2, p1, p0};
    endtask

    // One cycle: drive, check ready before the edge, check registered outputs after it
    task automatic stepVec(input string tag,
                           input logic [2:0] valid, input logic [2:0] hdr,
                           input logic [2:0] tail, input logic [3:0] credit,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2,
                           input logic [2:0] expReady, input logic expWe,
                           input logic [37:0] expFlit, input logic [3:0] expBusy);
        applyStimulus(valid, hdr, tail, credit, p0, p1, p2);
        #1;
        checkOutput({tag, "_ready"}, 64'(src_ready), 64'(expReady));
        @(posedge clk);
        #1;
        checkOutput({tag, "_we"}, 64'(flit_out_we), 64'(expWe));
        checkOutput({tag, "_flit"}, 64'(flit_out), 64'(expFlit));
        checkOutput({tag, "_busy"}, 64'(vc_busy), 64'(expBusy));
    endtask

    task automatic resetDut();
        applyStimulus(3'b000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        passCount  = 0;
        failCount  = 0;
        checkCount = 0;
        reset      = 1'b0;
        applyStimulus(3'b111, 3'b111, 3'b000, 4'b0000, 32'h1, 32'h2, 32'h3);

        // Reset held with every source requesting
        for (int c = 0; c < 3; c++) begin
            stepVec($sformatf("t1_rst%0d", c), 3'b111, 3'b111, 3'b000, 4'b0000,
                    32'h1, 32'h2, 32'h3, 3'b000, 1'b0, 38'h0, 4'b0000);
        end
        applyStimulus(3'b000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;

        // Four-flit packet on VC0, then the drained VC0 is skipped for VC1
        stepVec("t2_f0", 3'b001, 3'b001, 3'b000, 4'b0, 32'hA0, 0, 0,
                3'b001, 1'b1, fl(1, 0, 4'b0001, 32'hA0), 4'b0001);
        stepVec("t2_f1", 3'b001, 3'b000, 3'b000, 4'b0, 32'hA1, 0, 0,
                3'b001, 1'b1, fl(0, 0, 4'b0001, 32'hA1), 4'b0001);
        stepVec("t2_f2", 3'b001, 3'b000, 3'b000, 4'b0, 32'hA2, 0, 0,
                3'b001, 1'b1, fl(0, 0, 4'b0001, 32'hA2), 4'b0001);
        stepVec("t2_f3", 3'b001, 3'b000, 3'b001, 4'b0, 32'hA3, 0, 0,
                3'b001, 1'b1, fl(0, 1, 4'b0001, 32'hA3), 4'b0000);
        stepVec("t2_newhdr", 3'b001, 3'b001, 3'b000, 4'b0, 32'hA4, 0, 0,
                3'b001, 1'b1, fl(1, 0, 4'b0010, 32'hA4), 4'b0010);
        stepVec("t2_newtail", 3'b001, 3'b000, 3'b001, 4'b0, 32'hA5, 0, 0,
                3'b001, 1'b1, fl(0, 1, 4'b0010, 32'hA5), 4'b0000);
        stepVec("t2_idle", 3'b000, 3'b000, 3'b000, 4'b0, 0, 0, 0,
                3'b000, 1'b0, fl(0, 1, 4'b0010, 32'hA5), 4'b0000);

        // Credit starvation: fifth flit waits for a returned credit
        resetDut();
        stepVec("t3_f0", 3'b010, 3'b010, 3'b000, 4'b0, 0, 32'hB0, 0,
                3'b010, 1'b1, fl(1, 0, 4'b0001, 32'hB0), 4'b0001);
        stepVec("t3_f1", 3'b010, 3'b000, 3'b000, 4'b0, 0, 32'hB1, 0,
                3'b010, 1'b1, fl(0, 0, 4'b0001, 32'hB1), 4'b0001);
        stepVec("t3_f2", 3'b010, 3'b000, 3'b000, 4'b0, 0, 32'hB2, 0,
                3'b010, 1'b1, fl(0, 0, 4'b0001, 32'hB2), 4'b0001);
        stepVec("t3_f3", 3'b010, 3'b000, 3'b000, 4'b0, 0, 32'hB3, 0,
                3'b010, 1'b1, fl(0, 0, 4'b0001, 32'hB3), 4'b0001);
        stepVec("t3_stall0", 3'b010, 3'b000, 3'b010, 4'b0, 0, 32'hB4, 0,
                3'b000, 1'b0, fl(0, 0, 4'b0001, 32'hB3), 4'b0001);
        stepVec("t3_stall1", 3'b010, 3'b000, 3'b010, 4'b0, 0, 32'hB4, 0,
                3'b000, 1'b0, fl(0, 0, 4'b0001, 32'hB3), 4'b0001);
        stepVec("t3_pulse", 3'b010, 3'b000, 3'b010, 4'b0001, 0, 32'hB4, 0,
                3'b000, 1'b0, fl(0, 0, 4'b0001, 32'hB3), 4'b0001);
        stepVec("t3_f4", 3'b010, 3'b000, 3'b010, 4'b0, 0, 32'hB4, 0,
                3'b010, 1'b1, fl(0, 1, 4'b0001, 32'hB4), 4'b0000);

        // Three concurrent 3-flit packets interleave 0,1,2 on VC0/VC1/VC2
        resetDut();
        for (int s = 0; s < 3; s++) flitIdx[s] = 0;
        for (int c = 0; c < 9; c++) begin
            winner = c % 3;
            for (int s = 0; s < 3; s++) begin
                vValid[s] = (flitIdx[s] < 3);
                vHdr[s]   = (flitIdx[s] == 0);
                vTail[s]  = (flitIdx[s] == 2);
                pay[s]    = 32'hC000_0000 | 32'(s << 8) | 32'(flitIdx[s]);
            end
            vBusy = '0;
            for (int s = 0; s < 3; s++) vBusy[s] = (c >= s) && (c < 6 + s);
            stepVec($sformatf("t4_c%0d", c), vValid, vHdr, vTail, 4'b0,
                    pay[0], pay[1], pay[2], 3'(1 << winner), 1'b1,
                    fl(vHdr[winner], vTail[winner], 4'(1 << winner), pay[winner]), vBusy);
            flitIdx[winner] = flitIdx[winner] + 1;
        end

        // No allocatable VC: header stalls until a tail frees VC2
        resetDut();
        for (int k = 0; k < 4; k++) begin
            stepVec($sformatf("t5_drain%0d", k), 3'b001, 3'b001, 3'b001, 4'b0,
                    32'hD0 + 32'(k), 0, 0,
                    3'b001, 1'b1, fl(1, 1, 4'b0001, 32'hD0 + 32'(k)), 4'b0000);
        end
        stepVec("t5_h1", 3'b010, 3'b010, 3'b000, 4'b0, 0, 32'hD4, 0,
                3'b010, 1'b1, fl(1, 0, 4'b0010, 32'hD4), 4'b0010);
        stepVec("t5_h2", 3'b100, 3'b100, 3'b000, 4'b0, 0, 0, 32'hD5,
                3'b100, 1'b1, fl(1, 0, 4'b0100, 32'hD5), 4'b0110);
        stepVec("t5_h0", 3'b001, 3'b001, 3'b000, 4'b0, 32'hD6, 0, 0,
                3'b001, 1'b1, fl(1, 0, 4'b1000, 32'hD6), 4'b1110);
        stepVec("t5_b0a", 3'b001, 3'b000, 3'b000, 4'b0, 32'hD7, 0, 0,
                3'b001, 1'b1, fl(0, 0, 4'b1000, 32'hD7), 4'b1110);
        stepVec("t5_b0b", 3'b001, 3'b000, 3'b000, 4'b0, 32'hD8, 0, 0,
                3'b001, 1'b1, fl(0, 0, 4'b1000, 32'hD8), 4'b1110);
        stepVec("t5_t0", 3'b001, 3'b000, 3'b001, 4'b0, 32'hD9, 0, 0,
                3'b001, 1'b1, fl(0, 1, 4'b1000, 32'hD9), 4'b0110);
        stepVec("t5_active", 3'b011, 3'b001, 3'b000, 4'b0, 32'hDA, 32'hDB, 0,
                3'b010, 1'b1, fl(0, 0, 4'b0010, 32'hDB), 4'b0110);
        stepVec("t5_stall", 3'b001, 3'b001, 3'b000, 4'b0, 32'hDA, 0, 0,
                3'b000, 1'b0, fl(0, 0, 4'b0010, 32'hDB), 4'b0110);
        stepVec("t5_free", 3'b101, 3'b001, 3'b100, 4'b0, 32'hDA, 0, 32'hDC,
                3'b100, 1'b1, fl(0, 1, 4'b0100, 32'hDC), 4'b0010);
        stepVec("t5_take", 3'b001, 3'b001, 3'b000, 4'b0, 32'hDA, 0, 0,
                3'b001, 1'b1, fl(1, 0, 4'b0100, 32'hDA), 4'b0110);

        // Grant plus credit return on VC0 leaves it at 4: four more fit before VC1
        resetDut();
        stepVec("t6_both", 3'b001, 3'b001, 3'b001, 4'b0001, 32'hE0, 0, 0,
                3'b001, 1'b1, fl(1, 1, 4'b0001, 32'hE0), 4'b0000);
        for (int k = 1; k < 5; k++) begin
            stepVec($sformatf("t6_single%0d", k), 3'b001, 3'b001, 3'b001, 4'b0,
                    32'hE0 + 32'(k), 0, 0,
                    3'b001, 1'b1, fl(1, 1, 4'b0001, 32'hE0 + 32'(k)), 4'b0000);
        end
        stepVec("t6_next_vc", 3'b001, 3'b001, 3'b001, 4'b0, 32'hE5, 0, 0,
                3'b001, 1'b1, fl(1, 1, 4'b0010, 32'hE5), 4'b0000);

        applyStimulus(3'b000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
